sdram_arbit: RTL and testbench

- Central arbiter/sequencer for the SDRAM controller. It sits between the init, auto-refresh, write and read sub-controllers and the SDRAM pins.
- After initialization completes, it grants the SDRAM command bus to one sub-controller at a time. Priority order: refresh > write > read.
- It muxes the granted owner's command, bank, address and data onto the SDRAM interface.
- It drives the bidirectional DQ bus only during write ownership.

---
 rtl/sdram_arbit_pkg.sv | 26 ++
 rtl/sdram_arbit_if.sv | 63 ++++++
 rtl/sdram_arbit.sv | 128 ++++++++++++
 tb/tb_sdram_arbit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbit_pkg.sv
// Shared constants for the SDRAM controller: bus widths, command encodings
// ({cs_n,ras_n,cas_n,we_n}) and the arbiter state encoding.
// Latency: n/a. Backpressure: n/a. Imported by the arbiter and sub-controllers.
package sdram_arbit_pkg;

  localparam int ADDR_W = 13;
  localparam int BANK_W = 2;
  localparam int DQ_W   = 16;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// Bundle between the arbiter, the init/refresh/write/read sub-controllers and
// the SDRAM command pins. Latency: n/a. Backpressure: level requests held
// until the matching one-cycle grant; owners release with a one-cycle end pulse.
// Modports: master = arbiter side, slave = sub-controllers plus pin observer.
interface sdram_arbit_if;
  import sdram_arbit_pkg::*;

  // init sub-controller
  logic              flag_init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  // auto-refresh sub-controller
  logic              ref_req;
  logic              ref_end;
  logic [3:0]        ref_cmd;
  logic [ADDR_W-1:0] ref_addr;
  logic              ref_en;
  // write sub-controller
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;
  logic [DQ_W-1:0]   wr_data;
  logic              wr_en;
  // read sub-controller
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_en;
  logic [DQ_W-1:0]   rd_data;
  // SDRAM command pins
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;

  modport master (
    input  flag_init_end, init_cmd, init_addr,
    input  ref_req, ref_end, ref_cmd, ref_addr,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en, rd_data,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_bank, sdram_addr
  );

  modport slave (
    output flag_init_end, init_cmd, init_addr,
    output ref_req, ref_end, ref_cmd, ref_addr,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en, rd_data,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_bank, sdram_addr
  );

endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: after init, grants the bus to refresh > write >
// read and muxes the owner's command/bank/address (and write data) to the pins.
// Latency: grant pulse one cycle after a request is seen in ARBIT; pins follow
// the registered state combinationally. Backpressure: requests wait until the
// arbiter is back in ARBIT; the current owner is never preempted.
// Ports: sclk, s_rst_n (async, active low), bus (sdram_arbit_if.master),
// sdram_dq (tri-state data bus, driven only while WRITE owns the bus).
module sdram_arbit
  import sdram_arbit_pkg::*;
(
  input  logic            sclk,
  input  logic            s_rst_n,
  sdram_arbit_if.master   bus,
  inout  wire [DQ_W-1:0]  sdram_dq
);

  arb_state_t        state_q, state_d;
  logic              ref_en_q, wr_en_q, rd_en_q;
  logic              ref_grant, wr_grant, rd_grant;
  logic [DQ_W-1:0]   rd_data_q;
  logic [3:0]        cmd_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [BANK_W-1:0] bank_mux;

  // Next state and grant decision. Requests are only looked at in ARBIT, so
  // an end pulse always costs one NOP cycle before the next owner is granted.
  always_comb begin
    state_d   = state_q;
    ref_grant = 1'b0;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.flag_init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.ref_req) begin
          state_d   = ST_AREF;
          ref_grant = 1'b1;
        end else if (bus.wr_req) begin
          state_d  = ST_WRITE;
          wr_grant = 1'b1;
        end else if (bus.rd_req) begin
          state_d  = ST_READ;
          rd_grant = 1'b1;
        end
      end
      ST_AREF: begin
        if (bus.ref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (bus.wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (bus.rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant flops load together with the state, so each enable is high exactly
  // for the first cycle in the new state and at most one can be set.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= ST_IDLE;
      ref_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_en_q  <= ref_grant;
      wr_en_q   <= wr_grant;
      rd_en_q   <= rd_grant;
      rd_data_q <= sdram_dq;
    end
  end

  // Pin mux keyed on the registered state only, so pins never glitch on
  // request inputs.
  always_comb begin
    cmd_mux  = CMD_NOP;
    addr_mux = '0;
    bank_mux = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      ST_AREF: begin
        cmd_mux  = bus.ref_cmd;
        addr_mux = bus.ref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = bus.wr_cmd;
        addr_mux = bus.wr_addr;
        bank_mux = bus.wr_bank;
      end
      ST_READ: begin
        cmd_mux  = bus.rd_cmd;
        addr_mux = bus.rd_addr;
        bank_mux = bus.rd_bank;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        bank_mux = '0;
      end
    endcase
  end

  assign bus.ref_en      = ref_en_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.sdram_cke   = 1'b1;
  assign bus.sdram_cs_n  = cmd_mux[3];
  assign bus.sdram_ras_n = cmd_mux[2];
  assign bus.sdram_cas_n = cmd_mux[1];
  assign bus.sdram_we_n  = cmd_mux[0];
  assign bus.sdram_bank  = bank_mux;
  assign bus.sdram_addr  = addr_mux;

  // DQ stays a plain inout so the tri-state driver sits at the pad boundary;
  // released whenever WRITE does not own the bus, including during reset.
  assign sdram_dq = (state_q == ST_WRITE) ? bus.wr_data : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: grant order, NOP gaps, DQ ownership and async reset.
// Expected grants are queued when requests/end pulses are driven and popped
// when a grant pulse is observed.
module tb_sdram_arbit;
  import sdram_arbit_pkg::*;

  localparam int OWN_REF = 1;
  localparam int OWN_WR  = 2;
  localparam int OWN_RD  = 3;
  localparam int OWN_MULTI = 7;

  logic            sclk;
  logic            s_rst_n;
  logic            tb_dq_oe;
  logic [DQ_W-1:0] tb_dq;
  wire  [DQ_W-1:0] sdram_dq;
  logic [3:0]      pin_cmd;

  int n_chk  = 0;
  int n_pass = 0;
  int grant_cnt = 0;
  int exp_q[$];

  sdram_arbit_if bus();

  sdram_arbit u_dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .bus      (bus),
    .sdram_dq (sdram_dq)
  );

  // Stands in for the SDRAM driving DQ during reads.
  assign sdram_dq = tb_dq_oe ? tb_dq : {DQ_W{1'bz}};
  assign pin_cmd  = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] own_cmd(input int own);
    case (own)
      OWN_REF: return CMD_AREF;
      OWN_WR:  return CMD_WR;
      OWN_RD:  return CMD_RD;
      default: return CMD_NOP;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] own_addr(input int own);
    case (own)
      OWN_REF: return 13'h0400;
      OWN_WR:  return 13'h0123;
      OWN_RD:  return 13'h0456;
      default: return '0;
    endcase
  endfunction

  // Grant monitor: every enable pulse must match the head of the queue, and
  // the pins in that cycle must already carry the new owner's command.
  always @(negedge sclk) begin : mon
    int obs;
    int ex;
    int n_en;
    n_en = int'(bus.ref_en) + int'(bus.wr_en) + int'(bus.rd_en);
    obs  = (n_en > 1) ? OWN_MULTI : bus.ref_en ? OWN_REF : bus.wr_en ? OWN_WR : bus.rd_en ? OWN_RD : 0;
    if (obs != 0) begin
      grant_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_grant", obs, 0);
      end else begin
        ex = exp_q.pop_front();
        chk("grant_owner", obs, ex);
        chk("grant_cmd", {28'd0, pin_cmd}, {28'd0, own_cmd(ex)});
        chk("grant_addr", {19'd0, bus.sdram_addr}, {19'd0, own_addr(ex)});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // Counts negedges until the monitor sees a grant; a timeout shows up as a
  // latency mismatch.
  task automatic wait_grant(input string tag, input int exp_lat);
    int start;
    int lat;
    start = grant_cnt;
    lat = 0;
    while (grant_cnt == start && lat < 50) begin
      @(negedge sclk);
      #1;
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst_n = 1'b0;
    tb_dq_oe = 1'b0;
    tb_dq = '0;
    bus.flag_init_end = 1'b0;
    bus.init_cmd  = CMD_PRE;  bus.init_addr = 13'h0032;
    bus.ref_req = 1'b0; bus.ref_end = 1'b0; bus.ref_cmd = CMD_AREF; bus.ref_addr = 13'h0400;
    bus.wr_req = 1'b0;  bus.wr_end = 1'b0;  bus.wr_cmd = CMD_WR;    bus.wr_addr = 13'h0123;
    bus.wr_bank = 2'd2; bus.wr_data = 16'h1234;
    bus.rd_req = 1'b0;  bus.rd_end = 1'b0;  bus.rd_cmd = CMD_RD;    bus.rd_addr = 13'h0456;
    bus.rd_bank = 2'd1;

    // Reset values
    #3;
    chk("rst_ref_en", bus.ref_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_cke", bus.sdram_cke, 1);
    chk("rst_cmd_init", pin_cmd, CMD_PRE);
    tick(3);
    s_rst_n = 1'b1;

    // IDLE ignores requests until init is done; flag rises at cycle 200
    bus.rd_req = 1'b1;
    tick(196);
    bus.rd_req = 1'b0;
    @(negedge sclk);
    chk("idle_cmd", pin_cmd, CMD_PRE);
    chk("idle_addr", bus.sdram_addr, 13'h0032);
    tick();
    bus.flag_init_end = 1'b1;
    @(negedge sclk);
    chk("idle_cmd_flag", pin_cmd, CMD_PRE);
    tick();
    @(negedge sclk);
    chk("arbit_nop", pin_cmd, CMD_NOP);
    chk("arbit_addr", bus.sdram_addr, 0);
    chk("arbit_bank", bus.sdram_bank, 0);

    // All three requests together: refresh first, then write, then read
    tick();
    exp_q.push_back(OWN_REF);
    bus.ref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    wait_grant("lat_ref_first", 2);
    tick();
    bus.ref_req = 1'b0;
    tick(2);
    bus.ref_end = 1'b1;
    exp_q.push_back(OWN_WR);
    tick();
    bus.ref_end = 1'b0;
    @(negedge sclk);
    chk("gap_ref_wr", pin_cmd, CMD_NOP);
    wait_grant("lat_wr_after_ref", 1);
    tick();
    bus.wr_req = 1'b0;

    // Write data on DQ for the whole WRITE ownership
    repeat (3) begin
      @(negedge sclk);
      chk("dq_write", sdram_dq, 16'h1234);
      chk("wr_bank_pins", bus.sdram_bank, 2);
    end
    tick();
    bus.wr_end = 1'b1;
    exp_q.push_back(OWN_RD);
    tick();
    bus.wr_end = 1'b0;
    tb_dq_oe = 1'b1;
    tb_dq = 16'hA5A5;
    @(negedge sclk);
    chk("gap_wr_rd", pin_cmd, CMD_NOP);
    wait_grant("lat_rd_after_wr", 1);
    // Sampled on the edge leaving the NOP cycle: only the bench drives DQ
    chk("dq_released", bus.rd_data, 16'hA5A5);

    // Refresh and write arrive mid-read: no preemption, refresh wins next
    tick();
    bus.rd_req = 1'b0;
    tb_dq = 16'hBEEF;
    tick();
    bus.ref_req = 1'b1;
    bus.wr_req = 1'b1;
    @(negedge sclk);
    chk("rd_data", bus.rd_data, 16'hBEEF);
    chk("rd_bank_pins", bus.sdram_bank, 1);
    tick(3);
    bus.rd_end = 1'b1;
    exp_q.push_back(OWN_REF);
    tick();
    bus.rd_end = 1'b0;
    @(negedge sclk);
    chk("gap_rd_ref", pin_cmd, CMD_NOP);
    wait_grant("lat_ref_over_wr", 1);
    tick();
    bus.ref_req = 1'b0;
    bus.ref_end = 1'b1;
    exp_q.push_back(OWN_WR);
    tick();
    bus.ref_end = 1'b0;
    tb_dq_oe = 1'b0;
    @(negedge sclk);
    chk("gap_ref_wr2", pin_cmd, CMD_NOP);
    wait_grant("lat_wr_after_ref2", 1);
    tick();
    bus.wr_req = 1'b0;

    // wr_end and rd_req in the same cycle: one NOP cycle, then read
    tick();
    bus.wr_end = 1'b1;
    bus.rd_req = 1'b1;
    exp_q.push_back(OWN_RD);
    tick();
    bus.wr_end = 1'b0;
    @(negedge sclk);
    chk("gap_wr_rd2", pin_cmd, CMD_NOP);
    wait_grant("lat_rd_one_gap", 1);
    tick();
    bus.rd_req = 1'b0;

    // End pulses from non-owners are ignored
    bus.wr_end = 1'b1;
    bus.ref_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    bus.ref_end = 1'b0;
    @(negedge sclk);
    chk("foreign_end_ignored", pin_cmd, CMD_RD);
    tick();
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;

    // Async reset in the first WRITE cycle
    bus.wr_req = 1'b1;
    exp_q.push_back(OWN_WR);
    wait_grant("lat_wr_before_rst", 2);
    chk("wr_en_before_rst", bus.wr_en, 1);
    s_rst_n = 1'b0;
    bus.wr_req = 1'b0;
    tb_dq_oe = 1'b1;
    tb_dq = 16'hA5A5;
    #1;
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_ref_en", bus.ref_en, 0);
    chk("mid_rst_rd_en", bus.rd_en, 0);
    chk("mid_rst_rd_data", bus.rd_data, 0);
    chk("mid_rst_cke", bus.sdram_cke, 1);
    chk("mid_rst_cmd", pin_cmd, CMD_PRE);
    chk("mid_rst_bank", bus.sdram_bank, 0);
    chk("mid_rst_dq", sdram_dq, 16'hA5A5);
    tick(2);
    s_rst_n = 1'b1;
    @(negedge sclk);
    chk("post_rst_idle", pin_cmd, CMD_PRE);
    tick();
    @(negedge sclk);
    chk("post_rst_arbit", pin_cmd, CMD_NOP);
    tick(2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
